// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: measures the high time of a 50 Hz servo pulse and converts it to a 0-180 angle,
// with pulse-error and loss-of-signal reporting. Define SERVO_PWM_DECODER_GLITCH_FILTER_EN for an input debounce stage.
module servo_pwm_decoder #(
    parameter int unsigned PULSE_MIN    = 50_000,
    parameter int unsigned PULSE_MAX    = 100_000,
    parameter int unsigned REJECT_MIN   = 25_000,
    parameter int unsigned REJECT_MAX   = 150_000,
    parameter int unsigned LOST_TIMEOUT = 1_500_000,
    parameter int unsigned CNT_W        = 21,
    parameter int unsigned FILTER_LEN   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [7:0]       angle,
    output logic             angle_valid,
    output logic [CNT_W-1:0] pulse_width,
    output logic             pulse_err,
    output logic             signal_lost
);

    localparam int unsigned PROD_W = CNT_W + 8;
    localparam int unsigned SPAN   = PULSE_MAX - PULSE_MIN;

    if (FILTER_LEN == 0 || SPAN == 0 ||
        (CNT_W < 32 && LOST_TIMEOUT >= (32'd1 << CNT_W))) begin : g_cfg_check
        $error("servo_pwm_decoder: invalid parameter set");
    end

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        HIGH     = 2'd2,
        CONVERT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   width_cnt_q, width_cnt_d;
    logic [CNT_W-1:0]   since_q, since_d;
    logic [CNT_W-1:0]   pulse_width_q, pulse_width_d;
    logic [7:0]         angle_q, angle_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               lost_q, lost_d;

    logic               sync1_q, sync2_q;
    logic               level, level_prev;
    logic               rise, fall;

    logic [CNT_W-1:0]   w_clamp;
    logic [PROD_W-1:0]  prod;
    logic [7:0]         angle_c;

    // Synchronizer resets high so a pin still high after reset is treated as an interrupted pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef SERVO_PWM_DECODER_GLITCH_FILTER_EN
    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);

    logic             flt_q, flt_prev_q;
    logic [FLT_W-1:0] flt_cnt_q;

    // Debounce: follow sync2 only after it has held a new value FILTER_LEN cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            flt_q      <= 1'b1;
            flt_prev_q <= 1'b1;
            flt_cnt_q  <= '0;
        end else begin
            flt_prev_q <= flt_q;
            if (sync2_q == flt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
                flt_q     <= sync2_q;
                flt_cnt_q <= '0;
            end else begin
                flt_cnt_q <= flt_cnt_q + FLT_W'(1);
            end
        end
    end

    assign level      = flt_q;
    assign level_prev = flt_prev_q;
`else
    logic sync3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync3_q <= 1'b1;
        end else begin
            sync3_q <= sync2_q;
        end
    end

    assign level      = sync2_q;
    assign level_prev = sync3_q;
`endif

    assign rise = level & ~level_prev;
    assign fall = ~level & level_prev;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_LOW;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_LOW: if (!level) state_d = IDLE;
            IDLE:     if (rise) state_d = HIGH;
            HIGH: begin
                if (fall) begin
                    state_d = (width_cnt_q < CNT_W'(REJECT_MIN)) ? IDLE : CONVERT;
                end else if (width_cnt_q >= CNT_W'(REJECT_MAX)) begin
                    state_d = WAIT_LOW;
                end
            end
            CONVERT:  state_d = IDLE;
            default:  state_d = WAIT_LOW;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        width_cnt_d   = width_cnt_q;
        angle_d       = angle_q;
        pulse_width_d = pulse_width_q;
        valid_d       = 1'b0;
        err_d         = 1'b0;
        case (state_q)
            WAIT_LOW: width_cnt_d = '0;
            IDLE:     if (rise) width_cnt_d = CNT_W'(1);
            HIGH: begin
                if (fall) begin
                    err_d = (width_cnt_q < CNT_W'(REJECT_MIN));
                end else begin
                    width_cnt_d = width_cnt_q + CNT_W'(1);
                    err_d       = (width_cnt_q >= CNT_W'(REJECT_MAX));
                end
            end
            CONVERT: begin
                angle_d       = angle_c;
                pulse_width_d = width_cnt_q;
                valid_d       = 1'b1;
            end
            default: width_cnt_d = '0;
        endcase
    end

    // Clamp and scale the latched width; the divisor is a constant.
    always_comb begin
        w_clamp = width_cnt_q;
        if (width_cnt_q < CNT_W'(PULSE_MIN)) begin
            w_clamp = CNT_W'(PULSE_MIN);
        end else if (width_cnt_q > CNT_W'(PULSE_MAX)) begin
            w_clamp = CNT_W'(PULSE_MAX);
        end
        prod    = PROD_W'(w_clamp - CNT_W'(PULSE_MIN)) * PROD_W'(180);
        angle_c = 8'(prod / PROD_W'(SPAN));
    end

    // Loss-of-signal timer; only a completed decode clears the lost flag.
    always_comb begin
        since_d = since_q;
        if (rise) begin
            since_d = '0;
        end else if (since_q != CNT_W'(LOST_TIMEOUT)) begin
            since_d = since_q + CNT_W'(1);
        end
        lost_d = lost_q | (since_q == CNT_W'(LOST_TIMEOUT));
        if (valid_d) begin
            lost_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            width_cnt_q   <= '0;
            since_q       <= '0;
            pulse_width_q <= '0;
            angle_q       <= '0;
            valid_q       <= 1'b0;
            err_q         <= 1'b0;
            lost_q        <= 1'b0;
        end else begin
            width_cnt_q   <= width_cnt_d;
            since_q       <= since_d;
            pulse_width_q <= pulse_width_d;
            angle_q       <= angle_d;
            valid_q       <= valid_d;
            err_q         <= err_d;
            lost_q        <= lost_d;
        end
    end

    assign angle       = angle_q;
    assign angle_valid = valid_q;
    assign pulse_width = pulse_width_q;
    assign pulse_err   = err_q;
    assign signal_lost = lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder with time constants scaled down by 100.
module tb_servo_pwm_decoder;

    localparam int unsigned PMIN = 500;
    localparam int unsigned PMAX = 1000;
    localparam int unsigned RMIN = 250;
    localparam int unsigned RMAX = 1500;
    localparam int unsigned LOST = 15000;
    localparam int unsigned CW   = 16;
    localparam int unsigned FL   = 8;
    localparam int          LOW  = 1600;
`ifdef SERVO_PWM_DECODER_GLITCH_FILTER_EN
    localparam int          EDLY = FL;
`else
    localparam int          EDLY = 0;
`endif

    localparam int HW [6]  = '{500, 625, 1000, 555, 1500, 250};
    localparam int EXA [6] = '{0,   45,  180,  19,  180,  0};

    logic          clk = 1'b0;
    logic          rst;
    logic          pwm_in;
    logic [7:0]    angle;
    logic          angle_valid;
    logic [CW-1:0] pulse_width;
    logic          pulse_err;
    logic          signal_lost;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_valid = 0, n_err = 0, n_both = 0;
    int valid_cyc = -1, err_cyc = -1;
    logic lost_at_valid = 1'b1;
    int rise_cyc = 0, fall_cyc = 0;

    servo_pwm_decoder #(
        .PULSE_MIN(PMIN), .PULSE_MAX(PMAX), .REJECT_MIN(RMIN), .REJECT_MAX(RMAX),
        .LOST_TIMEOUT(LOST), .CNT_W(CW), .FILTER_LEN(FL)
    ) dut (
        .clk(clk), .rst(rst), .pwm_in(pwm_in), .angle(angle), .angle_valid(angle_valid),
        .pulse_width(pulse_width), .pulse_err(pulse_err), .signal_lost(signal_lost)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder sampled on the falling edge.
    always @(negedge clk) begin
        if (angle_valid === 1'b1) begin
            n_valid       = n_valid + 1;
            valid_cyc     = cyc;
            lost_at_valid = signal_lost;
        end
        if (pulse_err === 1'b1) begin
            n_err   = n_err + 1;
            err_cyc = cyc;
        end
        if (angle_valid === 1'b1 && pulse_err === 1'b1) n_both = n_both + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_pulse(input int high, input int low);
        pwm_in   = 1'b1;
        rise_cyc = cyc;
        tick(high);
        pwm_in   = 1'b0;
        fall_cyc = cyc;
        tick(low);
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        pwm_in = 1'b0;
        tick(5);
        rst = 1'b0;
        tick(10);
        total++; if (angle !== 8'd0) begin bad++; $display("FAIL reset_angle got=%0d want=0", angle); end
        total++; if (angle_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", angle_valid); end
        total++; if (pulse_width !== CW'(0)) begin bad++; $display("FAIL reset_width got=%0d want=0", pulse_width); end
        total++; if (pulse_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", pulse_err); end
        total++; if (signal_lost !== 1'b0) begin bad++; $display("FAIL reset_lost got=%b want=0", signal_lost); end
    endtask

    task automatic test_nominal();
        int v0;
        for (int p = 0; p < 2; p++) begin
            v0 = n_valid;
            drive_pulse(750, LOW);
            total++; if (n_valid !== v0 + 1) begin bad++; $display("FAIL nominal_strobes got=%0d want=%0d", n_valid - v0, 1); end
            total++; if (angle !== 8'd90) begin bad++; $display("FAIL nominal_angle got=%0d want=90", angle); end
            total++; if (pulse_width !== CW'(750)) begin bad++; $display("FAIL nominal_width got=%0d want=750", pulse_width); end
            total++; if (valid_cyc !== fall_cyc + 4 + EDLY) begin bad++; $display("FAIL nominal_latency got=%0d want=%0d", valid_cyc - fall_cyc, 4 + EDLY); end
        end
    endtask

    task automatic test_angles();
        int v0, e0;
        for (int i = 0; i < 6; i++) begin
            v0 = n_valid;
            e0 = n_err;
            drive_pulse(HW[i], LOW);
            total++; if (n_valid !== v0 + 1) begin bad++; $display("FAIL angle_strobe[%0d] got=%0d want=1", HW[i], n_valid - v0); end
            total++; if (n_err !== e0) begin bad++; $display("FAIL angle_noerr[%0d] got=%0d want=0", HW[i], n_err - e0); end
            total++; if (angle !== 8'(EXA[i])) begin bad++; $display("FAIL angle_val[%0d] got=%0d want=%0d", HW[i], angle, EXA[i]); end
            total++; if (pulse_width !== CW'(HW[i])) begin bad++; $display("FAIL angle_width[%0d] got=%0d want=%0d", HW[i], pulse_width, HW[i]); end
        end
    endtask

    task automatic test_clamp_reject();
        int v0, e0;
        e0 = n_err;
        drive_pulse(400, LOW);
        total++; if (angle !== 8'd0) begin bad++; $display("FAIL clamp_angle got=%0d want=0", angle); end
        total++; if (pulse_width !== CW'(400)) begin bad++; $display("FAIL clamp_width got=%0d want=400", pulse_width); end
        total++; if (n_err !== e0) begin bad++; $display("FAIL clamp_noerr got=%0d want=0", n_err - e0); end
        drive_pulse(625, LOW);
        v0 = n_valid;
        e0 = n_err;
        drive_pulse(200, LOW);
        total++; if (n_err !== e0 + 1) begin bad++; $display("FAIL short_err got=%0d want=1", n_err - e0); end
        total++; if (err_cyc !== fall_cyc + 3 + EDLY) begin bad++; $display("FAIL short_err_time got=%0d want=%0d", err_cyc - fall_cyc, 3 + EDLY); end
        total++; if (n_valid !== v0) begin bad++; $display("FAIL short_novalid got=%0d want=0", n_valid - v0); end
        total++; if (angle !== 8'd45) begin bad++; $display("FAIL short_hold_angle got=%0d want=45", angle); end
        total++; if (pulse_width !== CW'(625)) begin bad++; $display("FAIL short_hold_width got=%0d want=625", pulse_width); end
        e0 = n_err;
        drive_pulse(249, LOW);
        total++; if (n_err !== e0 + 1) begin bad++; $display("FAIL rmin_edge_err got=%0d want=1", n_err - e0); end
        total++; if (n_valid !== v0) begin bad++; $display("FAIL n_both_strobe_check got=%0d want=0", n_valid - v0); end
    endtask

    task automatic test_stuck_high();
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        drive_pulse(2000, LOW);
        total++; if (n_err !== e0 + 1) begin bad++; $display("FAIL long_err got=%0d want=1", n_err - e0); end
        total++; if (err_cyc !== rise_cyc + int'(RMAX) + 3 + EDLY) begin bad++; $display("FAIL long_err_time got=%0d want=%0d", err_cyc - rise_cyc, int'(RMAX) + 3 + EDLY); end
        total++; if (n_valid !== v0) begin bad++; $display("FAIL long_novalid got=%0d want=0", n_valid - v0); end
        total++; if (pulse_width !== CW'(249) && pulse_width !== CW'(625)) begin bad++; $display("FAIL long_hold_width got=%0d want=625", pulse_width); end
        drive_pulse(750, LOW);
        total++; if (n_valid !== v0 + 1) begin bad++; $display("FAIL long_recover_strobe got=%0d want=1", n_valid - v0); end
        total++; if (angle !== 8'd90) begin bad++; $display("FAIL long_recover_angle got=%0d want=90", angle); end
    endtask

    task automatic test_lost();
        int target;
        drive_pulse(750, 10);
        target = rise_cyc + int'(LOST) + 3 + EDLY;
        tick(target - cyc);
        total++; if (signal_lost !== 1'b0) begin bad++; $display("FAIL lost_early got=%b want=0", signal_lost); end
        tick(1);
        total++; if (signal_lost !== 1'b1) begin bad++; $display("FAIL lost_set got=%b want=1", signal_lost); end
        total++; if (angle !== 8'd90) begin bad++; $display("FAIL lost_hold_angle got=%0d want=90", angle); end
        pwm_in = 1'b1;
        tick(300);
        total++; if (signal_lost !== 1'b1) begin bad++; $display("FAIL lost_bare_rise got=%b want=1", signal_lost); end
        tick(325);
        pwm_in = 1'b0;
        tick(LOW);
        total++; if (lost_at_valid !== 1'b0) begin bad++; $display("FAIL lost_clear_at_strobe got=%b want=0", lost_at_valid); end
        total++; if (signal_lost !== 1'b0) begin bad++; $display("FAIL lost_clear got=%b want=0", signal_lost); end
        total++; if (angle !== 8'd45) begin bad++; $display("FAIL lost_new_angle got=%0d want=45", angle); end
    endtask

    task automatic test_reset_mid_pulse();
        int v0, e0;
        pwm_in = 1'b1;
        tick(300);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        total++; if (angle !== 8'd0) begin bad++; $display("FAIL midrst_angle got=%0d want=0", angle); end
        total++; if (pulse_width !== CW'(0)) begin bad++; $display("FAIL midrst_width got=%0d want=0", pulse_width); end
        v0 = n_valid;
        e0 = n_err;
        tick(400);
        pwm_in = 1'b0;
        tick(LOW);
        total++; if (n_valid !== v0) begin bad++; $display("FAIL midrst_discard got=%0d want=0", n_valid - v0); end
        total++; if (n_err !== e0) begin bad++; $display("FAIL midrst_noerr got=%0d want=0", n_err - e0); end
        drive_pulse(625, LOW);
        total++; if (n_valid !== v0 + 1) begin bad++; $display("FAIL midrst_next_strobe got=%0d want=1", n_valid - v0); end
        total++; if (angle !== 8'd45) begin bad++; $display("FAIL midrst_next_angle got=%0d want=45", angle); end
    endtask

    task automatic test_glitch();
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        drive_pulse(3, LOW);
`ifdef SERVO_PWM_DECODER_GLITCH_FILTER_EN
        total++; if (n_err !== e0) begin bad++; $display("FAIL glitch_filtered_err got=%0d want=0", n_err - e0); end
`else
        total++; if (n_err !== e0 + 1) begin bad++; $display("FAIL glitch_err got=%0d want=1", n_err - e0); end
`endif
        total++; if (n_valid !== v0) begin bad++; $display("FAIL glitch_novalid got=%0d want=0", n_valid - v0); end
        total++; if (angle !== 8'd45) begin bad++; $display("FAIL glitch_hold_angle got=%0d want=45", angle); end
        total++; if (n_both !== 0) begin bad++; $display("FAIL err_valid_overlap got=%0d want=0", n_both); end
    endtask

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b0;
        test_reset();
        test_nominal();
        test_angles();
        test_clamp_reject();
        test_stuck_high();
        test_lost();
        test_reset_mid_pulse();
        test_glitch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
